// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } arb_state_e;

    typedef enum logic {
        REQ_FETCH,
        REQ_DATA
    } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requesters, plus the next value of
// the fetch starvation counter. Data normally wins; once fetch has been passed
// over STARVE_LIMIT times in a row it is forced through.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             fReq_i,
    input  logic             dReq_i,
    input  logic [CNT_W-1:0] starveCnt_i,
    output logic             grant_o,
    output req_id_e          winner_o,
    output logic [CNT_W-1:0] starveCnt_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic starved;

    assign starved = fReq_i && (starveCnt_i == LIMIT_C);

    // Data wins unless fetch is starved; the counter only grows while fetch waits.
    always_comb begin
        grant_o     = fReq_i | dReq_i;
        winner_o    = REQ_FETCH;
        starveCnt_o = starveCnt_i;
        if (dReq_i && !starved) begin
            winner_o = REQ_DATA;
            if (fReq_i) begin
                if (starveCnt_i == LIMIT_C) begin
                    starveCnt_o = starveCnt_i;
                end else begin
                    starveCnt_o = starveCnt_i + CNT_W'(1);
                end
            end else begin
                starveCnt_o = '0;
            end
        end else if (fReq_i) begin
            winner_o    = REQ_FETCH;
            starveCnt_o = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between an instruction fetch port and
// a load/store data port. Each access is IDLE -> ISSUE (-> WAIT for reads),
// with every output driven from a register.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = mem_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q;
    req_id_e           winner_q;
    logic              isWrite_q;
    logic [CNT_W-1:0]  starveCnt_q;
    logic [CNT_W-1:0]  starveCnt_d;
    logic              pickGrant;
    req_id_e           pickWinner;

    logic              fGnt_q;
    logic              dGnt_q;
    logic              fRvalid_q;
    logic              dRvalid_q;
    logic [DATA_W-1:0] fRdata_q;
    logic [DATA_W-1:0] dRdata_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic              memWren_q;
    logic [DATA_W-1:0] memWdata_q;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) uPick (
        .fReq_i      (f_req),
        .dReq_i      (d_req),
        .starveCnt_i (starveCnt_q),
        .grant_o     (pickGrant),
        .winner_o    (pickWinner),
        .starveCnt_o (starveCnt_d)
    );

    // Access sequencer: latch the winner in IDLE, present it to the RAM in
    // ISSUE, and capture read data in WAIT. Pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            winner_q    <= REQ_FETCH;
            isWrite_q   <= 1'b0;
            starveCnt_q <= '0;
            fGnt_q      <= 1'b0;
            dGnt_q      <= 1'b0;
            fRvalid_q   <= 1'b0;
            dRvalid_q   <= 1'b0;
            fRdata_q    <= '0;
            dRdata_q    <= '0;
            memAddr_q   <= '0;
            memWren_q   <= 1'b0;
            memWdata_q  <= '0;
        end else begin
            fGnt_q    <= 1'b0;
            dGnt_q    <= 1'b0;
            fRvalid_q <= 1'b0;
            dRvalid_q <= 1'b0;
            memWren_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pickGrant) begin
                        winner_q    <= pickWinner;
                        starveCnt_q <= starveCnt_d;
                        state_q     <= ST_ISSUE;
                        if (pickWinner == REQ_DATA) begin
                            dGnt_q     <= 1'b1;
                            memAddr_q  <= d_addr;
                            memWdata_q <= d_wdata;
                            memWren_q  <= d_we;
                            isWrite_q  <= d_we;
                        end else begin
                            fGnt_q     <= 1'b1;
                            memAddr_q  <= f_addr;
                            isWrite_q  <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= isWrite_q ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (winner_q == REQ_DATA) begin
                        dRdata_q  <= mem_rdata;
                        dRvalid_q <= 1'b1;
                    end else begin
                        fRdata_q  <= mem_rdata;
                        fRvalid_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign f_gnt     = fGnt_q;
    assign d_gnt     = dGnt_q;
    assign f_rvalid  = fRvalid_q;
    assign d_rvalid  = dRvalid_q;
    assign f_rdata   = fRdata_q;
    assign d_rdata   = dRdata_q;
    assign mem_addr  = memAddr_q;
    assign mem_wren  = memWren_q;
    assign mem_wdata = memWdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push their expected
// grant/write/read-data events into a queue, and a negedge monitor pops and
// compares them whenever the arbiter presents one.
module tb_mem_port_arbiter;

    typedef enum int {EV_FGNT, EV_DGNT, EV_WR, EV_FRV, EV_DRV} evKind_e;

    typedef struct {
        evKind_e     kind;
        logic [10:0] addr;
        logic [31:0] data;
    } expEvent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [10:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic [10:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [10:0] mem_addr;
    logic        mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] ram [0:2047];
    bit          ramLoaded = 1'b0;

    expEvent_t   expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    int          lastGnt = -1;
    int          expGap = 0;

    // Grant order for fetch and data both held: bit i set means fetch wins grant i.
    localparam logic [9:0] STARVE_PATTERN = 10'b10000_10000;

    mem_port_arbiter #(
        .STARVE_LIMIT (4),
        .ADDR_W       (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wren  (mem_wren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM model: read-before-write, data one cycle later.
    always @(posedge clk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < 2048; i++) ram[i] = 32'd0;
            ram[5]    = 32'hE281_1008;
            ram[7]    = 32'h1234_5678;
            ramLoaded = 1'b1;
        end
        mem_rdata <= ram[mem_addr];
        if (mem_wren) ram[mem_addr] = mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushEvent(input evKind_e k, input logic [10:0] a, input logic [31:0] d);
        expEvent_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic matchEvent(input evKind_e k, input logic [10:0] a, input logic [31:0] d, input string name);
        expEvent_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s unexpected event actual=%0d expected=none at %0t", name, k, $time);
        end else begin
            e = expQ.pop_front();
            checkOutput({name, "_kind"}, 32'(k), 32'(e.kind));
            if (k == EV_FGNT || k == EV_DGNT || k == EV_WR)
                checkOutput({name, "_addr"}, {21'd0, a}, {21'd0, e.addr});
            if (k == EV_WR || k == EV_FRV || k == EV_DRV)
                checkOutput({name, "_data"}, d, e.data);
        end
    endtask

    // Monitor: matches every grant, write strobe and read-data pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            cycleCnt++;
            if (f_gnt || d_gnt) begin
                checkOutput("gnt_exclusive", {31'd0, f_gnt & d_gnt}, 32'd0);
                if (expGap != 0 && lastGnt >= 0)
                    checkOutput("gnt_gap", 32'(cycleCnt - lastGnt), 32'(expGap));
                lastGnt = cycleCnt;
            end
            if (expGap == 0) lastGnt = -1;
            if (f_rvalid || d_rvalid)
                checkOutput("rvalid_exclusive", {31'd0, f_rvalid & d_rvalid}, 32'd0);
            if (f_gnt)    matchEvent(EV_FGNT, mem_addr, 32'd0, "f_gnt");
            if (d_gnt)    matchEvent(EV_DGNT, mem_addr, 32'd0, "d_gnt");
            if (mem_wren) matchEvent(EV_WR, mem_addr, mem_wdata, "mem_write");
            if (f_rvalid) matchEvent(EV_FRV, 11'd0, f_rdata, "f_rvalid");
            if (d_rvalid) matchEvent(EV_DRV, 11'd0, d_rdata, "d_rvalid");
        end
    end

    // Single access from an idle arbiter, with grant and read-data latency checks.
    task automatic applyStimulus(input bit isData, input bit we, input logic [10:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData);
        int lat;
        pushEvent(isData ? EV_DGNT : EV_FGNT, addr, 32'd0);
        if (we) pushEvent(EV_WR, addr, wdata);
        else    pushEvent(isData ? EV_DRV : EV_FRV, 11'd0, expData);
        if (isData) begin
            d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (isData ? d_gnt : f_gnt) break;
        end
        checkOutput("gnt_latency", 32'(lat), 32'd1);
        f_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        if (we) begin
            @(negedge clk);
            checkOutput("write_two_cycles_busy", {31'd0, busy}, 32'd0);
        end else begin
            lat = 0;
            while (lat < 20) begin
                @(negedge clk);
                lat++;
                if (isData ? d_rvalid : f_rvalid) break;
            end
            checkOutput("rvalid_latency", 32'(lat), 32'd2);
        end
        @(negedge clk);
    endtask

    // Runs with requests held until the given number of grants has been seen.
    task automatic runHeld(input int nGrants, input bit dropOnGnt);
        int seen = 0;
        int cyc = 0;
        while (seen < nGrants && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (f_gnt || d_gnt) seen++;
            if (dropOnGnt && f_gnt) f_req = 1'b0;
            if (dropOnGnt && d_gnt) d_req = 1'b0;
        end
        f_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        checkOutput("held_grant_count", 32'(seen), 32'(nGrants));
        repeat (4) @(negedge clk);
        expGap = 0;
        @(negedge clk);
    endtask

    // Directed stimulus sequence.
    initial begin
        rst = 1'b1;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_f_gnt",     {31'd0, f_gnt},    32'd0);
        checkOutput("rst_d_gnt",     {31'd0, d_gnt},    32'd0);
        checkOutput("rst_f_rvalid",  {31'd0, f_rvalid}, 32'd0);
        checkOutput("rst_d_rvalid",  {31'd0, d_rvalid}, 32'd0);
        checkOutput("rst_mem_wren",  {31'd0, mem_wren}, 32'd0);
        checkOutput("rst_busy",      {31'd0, busy},     32'd0);
        checkOutput("rst_mem_addr",  {21'd0, mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata,         32'd0);
        checkOutput("rst_f_rdata",   f_rdata,           32'd0);
        checkOutput("rst_d_rdata",   d_rdata,           32'd0);

        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] fetch-only read");
        applyStimulus(1'b0, 1'b0, 11'd5, 32'd0, 32'hE281_1008);

        $display("[TB] store then load at 29");
        applyStimulus(1'b1, 1'b1, 11'd29, 32'd8, 32'd0);
        applyStimulus(1'b1, 1'b0, 11'd29, 32'd0, 32'd8);

        $display("[TB] simultaneous fetch and data load");
        pushEvent(EV_DGNT, 11'd29, 32'd0);
        pushEvent(EV_DRV, 11'd0, 32'd8);
        pushEvent(EV_FGNT, 11'd5, 32'd0);
        pushEvent(EV_FRV, 11'd0, 32'hE281_1008);
        expGap = 3;
        f_req = 1'b1; f_addr = 11'd5;
        d_req = 1'b1; d_addr = 11'd29; d_we = 1'b0;
        runHeld(2, 1'b1);

        $display("[TB] starvation pattern with both held");
        for (int i = 0; i < 10; i++) begin
            if (STARVE_PATTERN[i]) begin
                pushEvent(EV_FGNT, 11'd5, 32'd0);
                pushEvent(EV_FRV, 11'd0, 32'hE281_1008);
            end else begin
                pushEvent(EV_DGNT, 11'd29, 32'd0);
                pushEvent(EV_DRV, 11'd0, 32'd8);
            end
        end
        expGap = 3;
        f_req = 1'b1; f_addr = 11'd5;
        d_req = 1'b1; d_addr = 11'd29; d_we = 1'b0;
        runHeld(10, 1'b0);

        $display("[TB] back-to-back loads");
        for (int i = 0; i < 3; i++) begin
            pushEvent(EV_DGNT, 11'd7, 32'd0);
            pushEvent(EV_DRV, 11'd0, 32'h1234_5678);
        end
        expGap = 3;
        d_req = 1'b1; d_addr = 11'd7; d_we = 1'b0;
        runHeld(3, 1'b0);

        $display("[TB] back-to-back stores");
        for (int i = 0; i < 3; i++) begin
            pushEvent(EV_DGNT, 11'd40, 32'd0);
            pushEvent(EV_WR, 11'd40, 32'hA5A5_A5A5);
        end
        expGap = 2;
        d_req = 1'b1; d_addr = 11'd40; d_we = 1'b1; d_wdata = 32'hA5A5_A5A5;
        runHeld(3, 1'b0);
        applyStimulus(1'b1, 1'b0, 11'd40, 32'd0, 32'hA5A5_A5A5);

        $display("[TB] reset during load wait");
        pushEvent(EV_DGNT, 11'd5, 32'd0);
        d_req = 1'b1; d_addr = 11'd5; d_we = 1'b0;
        begin
            int lat = 0;
            while (lat < 20) begin
                @(negedge clk);
                lat++;
                if (d_gnt) break;
            end
            checkOutput("abort_gnt_latency", 32'(lat), 32'd1);
        end
        d_req = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy",     {31'd0, busy},     32'd0);
        checkOutput("abort_d_rdata",  d_rdata,           32'd0);
        checkOutput("abort_f_rdata",  f_rdata,           32'd0);
        checkOutput("abort_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_d_rdata_after", d_rdata, 32'd0);

        $display("[TB] fetch after reset");
        applyStimulus(1'b0, 1'b0, 11'd5, 32'd0, 32'hE281_1008);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends even if the arbiter wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants issued while fetch is waiting.
REQ-002 Parameter ADDR_W, default 11: word-address width, 2048-word memory.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 f_req  in  1  fetch read request; held with f_addr until f_gnt.
REQ-006 f_addr  in  ADDR_W  fetch word address.
REQ-007 f_gnt  out  1  one-cycle pulse: fetch request issued to memory.
REQ-008 f_rvalid  out  1  one-cycle pulse: f_rdata valid.
REQ-009 f_rdata  out  32  fetched instruction word.
REQ-010 d_req  in  1  data request (LDR/STR); held with d_addr/d_we/d_wdata until d_gnt.
REQ-011 d_addr  in  ADDR_W  data word address.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_gnt  out  1  one-cycle pulse: data request issued.
REQ-015 d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only).
REQ-016 d_rdata  out  32  load data.
REQ-017 mem_addr  out  ADDR_W  single-port RAM address.
REQ-018 mem_wren  out  1  RAM write enable.
REQ-019 mem_wdata  out  32  RAM write data.
REQ-020 mem_rdata  in  32  RAM read data, valid one cycle after address presented.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT.
REQ-023 IDLE: if f_req or d_req, register winner, address, we, wdata; next ISSUE; else stay IDLE.
REQ-024 ISSUE: drive mem_addr/mem_wren/mem_wdata from registers; pulse winner's gnt; next WAIT if read, IDLE if write.
REQ-025 WAIT: capture mem_rdata into the winner's rdata register; winner's rvalid asserted in the following cycle; next IDLE.
REQ-026 Read latency: req sampled at edge N -> gnt during cycle N..N+1 -> rvalid during cycle N+2..N+3 (3 edges); write occupies 2 cycles.
REQ-027 A new request may be sampled in the same IDLE cycle that rvalid is high.
REQ-028 Arbitration: data wins over fetch unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-029 starve_cnt increments when data wins while f_req high; clears on any fetch win or a data win with f_req low; saturates at STARVE_LIMIT.
REQ-030 mem_wren high only in ISSUE of a store; 0 in all other cycles.
REQ-031 rdata registers hold their value until the next rvalid for the same port.
REQ-032 gnt and rvalid never asserted to both ports in the same cycle.
REQ-033 Requests arriving during ISSUE/WAIT are not sampled until IDLE; no queueing beyond the held req.

Reset
REQ-034 On rst: state IDLE, starve_cnt 0, all gnt/rvalid/mem_wren/busy 0, mem_addr 0, mem_wdata 0, f_rdata/d_rdata 0.
REQ-035 Reset during ISSUE or WAIT aborts the access: no gnt, no rvalid, no write after rst deasserts.

Structure
REQ-036 Package mem_arb_pkg holds the state enum, requester-ID enum (REQ_FETCH, REQ_DATA), ADDR_W and DATA_W constants.
REQ-037 One sub-module, mem_arb_pick: combinational winner select plus starvation-counter update.

Verification
REQ-038 f_req only, f_addr=5, mem[5]=0xE2811008 -> f_gnt one cycle, f_rvalid 2 cycles later, f_rdata=0xE2811008.
REQ-039 d_req store d_addr=29, d_wdata=8 -> mem_wren one cycle at addr 29; subsequent load from 29 returns d_rdata=8.
REQ-040 f_req and d_req held continuously -> grants D,D,D,D,F,D,D,D,D,F (STARVE_LIMIT=4).
REQ-041 Simultaneous f_req and d_req load with starve_cnt=0 -> d_gnt first, f_gnt at next IDLE; no cycle with both gnt high.
REQ-042 rst asserted during WAIT of a load -> no d_rvalid, busy=0, d_rdata=0 immediately.
REQ-043 Back-to-back loads, d_req held -> second d_gnt in the cycle after first d_rvalid's IDLE sample; sustained 3-cycle cadence.
